imm_gen_pipe: RTL and testbench

- Pipelined, parametrised immediate generator for the RISC-V decode path.
- Accepts full 32-bit instruction words over a valid/ready handshake.
- Selects the immediate format either from an explicit immSrc-style select or by decoding the opcode itself.
- Emits the sign-extended XLEN-wide immediate, its format code and an illegal flag after a fixed, parametrised latency; sits between fetch/decode and the execute operand muxes.

---
 rtl/imm_gen_pipe.sv | 226 ++++++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator for the decode path.
// It accepts 32-bit instruction words on a valid/ready handshake. It picks the
// immediate format either by decoding the opcode (AUTO_DECODE=1) or from the
// imm_src select (AUTO_DECODE=0). It returns the XLEN-wide extended immediate,
// the format code that was applied, and an illegal flag, PIPE_STAGES cycles
// after the word is accepted.
// Optional feature: define ZICSR_IMM_EN to make format 101 (CSR zimm) legal.
// With it, csr*i opcodes (funct3[2]=1) decode to format 101.
module imm_gen_pipe #(
  parameter int XLEN        = 32,   // 32 or 64
  parameter int PIPE_STAGES = 1,    // 1 or 2
  parameter bit AUTO_DECODE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,        // asynchronous, active-low
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_src,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      imm_fmt,
  output logic            illegal
);

  typedef enum logic [2:0] {
    FMT_I   = 3'b000,
    FMT_S   = 3'b001,
    FMT_B   = 3'b010,
    FMT_J   = 3'b011,
    FMT_U   = 3'b100,
    FMT_Z   = 3'b101,
    FMT_BAD = 3'b111
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            illegal;
  } result_t;

  // Maps an instruction, or the explicit select, to the format that will be
  // applied. Every unsupported case collapses to FMT_BAD, so the output
  // side only has to recognise one illegal code.
  function automatic fmt_e decode_fmt(input logic [31:0] w, input logic [2:0] src);
    fmt_e f;
    f = FMT_BAD;
    if (AUTO_DECODE) begin
      case (w[6:0])
        7'b0010011, 7'b0000011, 7'b1100111: f = FMT_I;
        7'b1110011: begin
`ifdef ZICSR_IMM_EN
          f = w[14] ? FMT_Z : FMT_I;
`else
          f = FMT_I;
`endif
        end
        7'b0100011:             f = FMT_S;
        7'b1100011:             f = FMT_B;
        7'b1101111:             f = FMT_J;
        7'b0110111, 7'b0010111: f = FMT_U;
        default:                f = FMT_BAD;
      endcase
    end else begin
      case (src)
        3'b000:  f = FMT_I;
        3'b001:  f = FMT_S;
        3'b010:  f = FMT_B;
        3'b011:  f = FMT_J;
        3'b100:  f = FMT_U;
`ifdef ZICSR_IMM_EN
        3'b101:  f = FMT_Z;
`endif
        default: f = FMT_BAD;
      endcase
    end
    return f;
  endfunction

  // Builds the 32-bit signed immediate, then widens it to XLEN. Only
  // instr[31:7] carries immediate bits, so the opcode field is not passed in.
  function automatic result_t extend(input logic [31:7] w, input fmt_e f);
    result_t    r;
    logic [31:0] raw;
    case (f)
      FMT_I:   raw = {{20{w[31]}}, w[31:20]};
      FMT_S:   raw = {{20{w[31]}}, w[31:25], w[11:7]};
      FMT_B:   raw = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      FMT_J:   raw = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      FMT_U:   raw = {w[31:12], 12'b0};
      default: raw = '0;
    endcase
    r.imm     = XLEN'($signed(raw));
    r.fmt     = f;
    r.illegal = 1'b0;
`ifdef ZICSR_IMM_EN
    if (f == FMT_Z) r.imm = XLEN'(w[19:15]);
`endif
    if (f == FMT_BAD) begin
      r.imm     = '0;
      r.illegal = 1'b1;
    end
    return r;
  endfunction

  // Interface between the optional decode stage and the output register.
  logic        s_valid;
  logic        s_ready;
  logic [31:7] s_instr;
  fmt_e        s_fmt;
  result_t     s_res;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] imm_q, imm_d;
  fmt_e            fmt_q, fmt_d;
  logic            illegal_q, illegal_d;

  // The output register can take a word if it is empty, or if its current
  // word leaves this cycle.
  always_comb s_ready = !out_valid_q || out_ready;

  if (PIPE_STAGES == 1) begin : g_single
    // Single stage: decode and extension both feed the output register directly.
    always_comb begin
      s_valid  = in_valid && !flush;
      s_instr  = instr[31:7];
      s_fmt    = decode_fmt(instr, imm_src);
      in_ready = s_ready && !flush;
    end
  end else begin : g_double
    logic        v1_q, v1_d;
    logic [31:7] instr1_q, instr1_d;
    fmt_e        fmt1_q, fmt1_d;
    logic        ready1;

    // Decode stage: it holds the instruction and its selected format until the
    // output register frees up. A flush drops the held word and blocks the
    // word offered in the same cycle.
    always_comb begin
      // NOTE: every signal written here gets a default value first. That way
      // no path leaves a variable unassigned and no latch is inferred.
      v1_d     = v1_q;
      instr1_d = instr1_q;
      fmt1_d   = fmt1_q;
      ready1   = !v1_q || s_ready;
      in_ready = ready1 && !flush;
      if (flush) begin
        v1_d = 1'b0;
      end else if (ready1) begin
        v1_d = in_valid;
        if (in_valid) begin
          instr1_d = instr[31:7];
          fmt1_d   = decode_fmt(instr, imm_src);
        end
      end
    end

    // Decode-stage valid bit. Resetting it is what empties the stage.
    always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments only. Every flop
      // then samples values from before the edge, whatever order the blocks
      // are evaluated in.
      if (!rst) v1_q <= 1'b0;
      else      v1_q <= v1_d;
    end

    // Decode-stage payload. It is only read while v1_q is set.
    always_ff @(posedge clk) begin
      // NOTE: these data flops are deliberately not reset. Their valid bit
      // already masks stale contents, and leaving them out keeps the reset
      // tree small.
      instr1_q <= instr1_d;
      fmt1_q   <= fmt1_d;
    end

    // The next stage sees the registered decode result.
    always_comb begin
      s_valid = v1_q;
      s_instr = instr1_q;
      s_fmt   = fmt1_q;
    end
  end

  // Output stage: it loads an extended result when there is room. It holds
  // the result while the consumer stalls, and a flush empties it.
  always_comb begin
    s_res       = extend(s_instr, s_fmt);
    out_valid_d = out_valid_q;
    imm_d       = imm_q;
    fmt_d       = fmt_q;
    illegal_d   = illegal_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (s_ready) begin
      out_valid_d = s_valid;
      if (s_valid) begin
        imm_d     = s_res.imm;
        fmt_d     = s_res.fmt;
        illegal_d = s_res.illegal;
      end
    end
  end

  // Output register. All visible outputs read zero while reset is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      imm_q       <= '0;
      fmt_q       <= FMT_I;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      imm_q       <= imm_d;
      fmt_q       <= fmt_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign imm       = imm_q;
  assign imm_fmt   = fmt_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: bench for imm_gen_pipe. Two instances share one stimulus:
// A uses XLEN=32, 1 stage and auto-decode; B uses XLEN=64, 2 stages and
// explicit imm_src. Define ZICSR_IMM_EN to build the zimm variant.
`timescale 1ns/1ps
module tb_imm_gen_pipe;

`ifdef ZICSR_IMM_EN
  localparam bit ZICSR = 1'b1;
`else
  localparam bit ZICSR = 1'b0;
`endif

  localparam int PIPE_A = 1;
  localparam int PIPE_B = 2;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [2:0]  imm_src;

  logic        in_ready_a, out_valid_a, illegal_a;
  logic [31:0] imm_a;
  logic [2:0]  fmt_a;
  logic        in_ready_b, out_valid_b, illegal_b;
  logic [63:0] imm_b;
  logic [2:0]  fmt_b;

  imm_gen_pipe #(.XLEN(32), .PIPE_STAGES(PIPE_A), .AUTO_DECODE(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .instr(instr), .imm_src(imm_src), .out_valid(out_valid_a), .out_ready(out_ready),
    .imm(imm_a), .imm_fmt(fmt_a), .illegal(illegal_a));

  imm_gen_pipe #(.XLEN(64), .PIPE_STAGES(PIPE_B), .AUTO_DECODE(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .instr(instr), .imm_src(imm_src), .out_valid(out_valid_b), .out_ready(out_ready),
    .imm(imm_b), .imm_fmt(fmt_b), .illegal(illegal_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance views so that one monitor loop can serve both instances.
  logic        rdy_w [2];
  logic        ov_w  [2];
  logic [63:0] imm_w [2];
  logic [2:0]  fmt_w [2];
  logic        ill_w [2];
  always_comb begin
    rdy_w[0] = in_ready_a;  rdy_w[1] = in_ready_b;
    ov_w[0]  = out_valid_a; ov_w[1]  = out_valid_b;
    imm_w[0] = {32'b0, imm_a}; imm_w[1] = imm_b;
    fmt_w[0] = fmt_a;       fmt_w[1] = fmt_b;
    ill_w[0] = illegal_a;   ill_w[1] = illegal_b;
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    int          t;
  } exp_t;

  // Reference model. It computes the immediate as a signed integer value
  // from the decoding rules, then truncates it to the instance width.
  function automatic exp_t ref_model(input logic [31:0] w, input logic [2:0] src,
                                     input bit auto_dec, input int xlen);
    exp_t   e;
    int     f;
    longint v;
    if (auto_dec) begin
      case (w[6:0])
        7'h13, 7'h03, 7'h67: f = 0;
        7'h73:               f = (ZICSR && w[14]) ? 5 : 0;
        7'h23:               f = 1;
        7'h63:               f = 2;
        7'h6f:               f = 3;
        7'h37, 7'h17:        f = 4;
        default:             f = 7;
      endcase
    end else begin
      f = int'(src);
      if (f == 6 || (f == 5 && !ZICSR)) f = 7;
    end
    case (f)
      0:       v = longint'($signed(w[31:20]));
      1:       v = longint'($signed({w[31:25], w[11:7]}));
      2:       v = longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      3:       v = longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      4:       v = longint'($signed(w[31:12])) * 4096;
      5:       v = longint'(w[19:15]);
      default: v = 0;
    endcase
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    e.imm = v;
    e.fmt = 3'(f);
    e.ill = (f == 7);
    e.t   = 0;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(7) != 0) begin
      case ($urandom_range(9))
        0: w[6:0] = 7'h13;  1: w[6:0] = 7'h03;  2: w[6:0] = 7'h67;
        3: w[6:0] = 7'h73;  4: w[6:0] = 7'h23;  5: w[6:0] = 7'h63;
        6: w[6:0] = 7'h6f;  7: w[6:0] = 7'h37;  8: w[6:0] = 7'h17;
        default: w[6:0] = 7'h33;
      endcase
    end
    return w;
  endfunction

  // Scoreboard: words accepted but not yet consumed, oldest first, per instance.
  exp_t sb [2][$];

  // Per-cycle monitor. It checks the handshake against queue occupancy, checks
  // out_valid against the age of the oldest word, and checks the payload
  // against the head of the queue. Then it applies this cycle's transfers.
  always @(negedge clk) begin
    exp_t f;
    int   p;
    bit   exp_ov, exp_ir;
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        p      = (d == 0) ? PIPE_A : PIPE_B;
        exp_ir = !flush && (sb[d].size() < p || out_ready);
        exp_ov = (sb[d].size() > 0) && (sb[d][0].t + p <= cyc);
        check($sformatf("in_ready[%0d]", d), rdy_w[d], exp_ir);
        check($sformatf("out_valid[%0d]", d), ov_w[d], exp_ov);
        if (ov_w[d] && sb[d].size() > 0) begin
          check($sformatf("imm[%0d]", d), imm_w[d], sb[d][0].imm);
          check($sformatf("imm_fmt[%0d]", d), fmt_w[d], sb[d][0].fmt);
          check($sformatf("illegal[%0d]", d), ill_w[d], sb[d][0].ill);
        end
        if (flush) begin
          sb[d].delete();
        end else begin
          if (ov_w[d] && out_ready && sb[d].size() > 0) void'(sb[d].pop_front());
          if (in_valid && rdy_w[d]) begin
            f   = ref_model(instr, imm_src, d == 0, (d == 0) ? 32 : 64);
            f.t = cyc;
            sb[d].push_back(f);
          end
        end
      end
    end
    cyc++;
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ov_a"},  out_valid_a, 0);
    check({tag, "_imm_a"}, imm_a, 0);
    check({tag, "_fmt_a"}, fmt_a, 0);
    check({tag, "_ill_a"}, illegal_a, 0);
    check({tag, "_ov_b"},  out_valid_b, 0);
    check({tag, "_imm_b"}, imm_b, 0);
    check({tag, "_fmt_b"}, fmt_b, 0);
    check({tag, "_ill_b"}, illegal_b, 0);
  endtask

  // Sends one word into empty pipes and checks each instance at its exact
  // latency against hand-computed constants.
  task automatic directed(input string tag, input logic [31:0] w, input logic [2:0] src,
                          input logic [63:0] ia, input logic [2:0] fa,
                          input logic [63:0] ib, input logic [2:0] fb);
    @(posedge clk); #1;
    in_valid = 1'b1; instr = w; imm_src = src; out_ready = 1'b1; flush = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_ov_a"},  out_valid_a, 1);
    check({tag, "_imm_a"}, imm_a, ia);
    check({tag, "_fmt_a"}, fmt_a, fa);
    check({tag, "_ill_a"}, illegal_a, fa == 3'd7);
    check({tag, "_early_b"}, out_valid_b, 0);
    @(negedge clk);
    check({tag, "_ov_b"},  out_valid_b, 1);
    check({tag, "_imm_b"}, imm_b, ib);
    check({tag, "_fmt_b"}, fmt_b, fb);
    check({tag, "_ill_b"}, illegal_b, fb == 3'd7);
  endtask

  initial begin
    exp_t tmp;
    bit   resumed;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; imm_src = '0;
    #1;
    check_idle_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Known vectors from hand decoding.
    directed("addi", 32'hFFF00093, 3'd0, 64'hFFFFFFFF, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0);
    directed("sw",   32'hFE112E23, 3'd1, 64'hFFFFFFFC, 3'd1, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1);
    directed("jal",  32'hFFDFF06F, 3'd3, 64'hFFFFFFFC, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3);
    directed("lui",  32'h123452B7, 3'd4, 64'h12345000, 3'd4, 64'h0000_0000_1234_5000, 3'd4);
    directed("luin", 32'h800002B7, 3'd4, 64'h80000000, 3'd4, 64'hFFFF_FFFF_8000_0000, 3'd4);
    directed("bad",  32'h00000000, 3'd6, 64'h0, 3'd7, 64'h0, 3'd7);
`ifdef ZICSR_IMM_EN
    directed("csrwi", 32'h3401D073, 3'd5, 64'h3, 3'd5, 64'h3, 3'd5);
`else
    directed("csrwi", 32'h3401D073, 3'd5, 64'h340, 3'd0, 64'h0, 3'd7);
`endif

    // Back-pressure: three back-to-back words while the consumer stalls.
    @(posedge clk); #1;
    in_valid = 1'b1; instr = 32'hFFF00093; imm_src = 3'd0; out_ready = 1'b0;
    @(posedge clk); #1;
    instr = 32'h123452B7; imm_src = 3'd4;
    @(negedge clk);
    check("bp_half_b", in_ready_b, 1);
    @(posedge clk); #1;
    instr = 32'h00000000; imm_src = 3'd6;
    @(negedge clk);
    check("bp_full_b", in_ready_b, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    resumed = 1'b0;
    for (int i = 0; i < 8 && !resumed; i++) begin
      @(negedge clk);
      resumed = in_ready_b;
    end
    check("bp_resume_b", resumed, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);

    // Flush of full pipes, with a word offered in the same cycle.
    #1;
    in_valid = 1'b1; instr = 32'h00A00093; imm_src = 3'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1; instr = 32'h00100093;
    @(negedge clk);
    check("flush_rdy_a", in_ready_a, 0);
    check("flush_rdy_b", in_ready_b, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("flush_ov_a", out_valid_a, 0);
    check("flush_ov_b", out_valid_b, 0);
    directed("post_flush", 32'h12345037, 3'd4, 64'h12345000, 3'd4, 64'h0000_0000_1234_5000, 3'd4);

    // Randomized traffic with alternating stall-heavy and flowing phases.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(3) != 0);
      instr    = rand_instr();
      tmp      = ref_model(instr, 3'd0, 1'b1, 64);
      imm_src  = ($urandom_range(3) != 0) ? tmp.fmt : 3'($urandom_range(7));
      out_ready = ((i % 200) < 100) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
      flush    = ($urandom_range(40) == 0);
    end

    // Drain, bounded by a cycle budget.
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && (sb[0].size() + sb[1].size()) != 0; i++) @(posedge clk);
    @(negedge clk);
    check("drain_a", sb[0].size(), 0);
    check("drain_b", sb[1].size(), 0);
    check("drain_ov_a", out_valid_a, 0);
    check("drain_ov_b", out_valid_b, 0);

    // Reset asserted between clock edges while both outputs hold valid words.
    @(posedge clk); #1;
    in_valid = 1'b1; instr = 32'hFFF00093; imm_src = 3'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_rst_ov_a", out_valid_a, 1);
    check("pre_rst_ov_b", out_valid_b, 1);
    #2 rst = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    sb[0].delete();
    sb[1].delete();
    in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("post_rst_ov_a", out_valid_a, 0);
    check("post_rst_ov_b", out_valid_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
